// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter that time-shares one WIDTH-bit adder
// between NREQ requesters and returns sum, carry and requester ID over a
// valid/ready response port, counting completed responses.
module adder_share_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic [ID_W:0]    cand_ext;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [ID_W-1:0]  lat_id;
  logic [WIDTH:0]   full_sum;

  // Round-robin search: first set req bit starting just after the last winner.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    cand_ext  = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_ext = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand_ext >= (ID_W+1)'(NREQ)) begin
        cand_ext = cand_ext - (ID_W+1)'(NREQ);
      end
      cand = cand_ext[ID_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Select the winning requester's operand slices.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_a = op_a[i*WIDTH +: WIDTH];
        win_b = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign full_sum = {1'b0, lat_a} + {1'b0, lat_b};
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: req only matters in IDLE, rsp_ready only in RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch winner, produce the registered sum, handshake and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= ID_W'(NREQ - 1);
      gnt       <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            lat_a  <= win_a;
            lat_b  <= win_b;
            lat_id <= win_id;
            ptr    <= win_id;
            gnt    <= NREQ'(1) << win_id;
          end else begin
            gnt <= '0;
          end
        end
        EXEC: begin
          gnt       <= '0;
          rsp_sum   <= full_sum[WIDTH-1:0];
          rsp_carry <= full_sum[WIDTH];
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (ops_done != '1) begin
              ops_done <= ops_done + CNT_W'(1);
            end
          end
        end
        default: begin
          gnt       <= '0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed stimulus with hand-computed expectations plus
// a transaction-level reference model compared against two instances
// (16-bit and 2-bit completion counters) on every falling clock edge.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  a_arr [4];
  logic [7:0]  b_arr [4];
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rsp_ready;

  logic [3:0]  gnt,   gnt2;
  logic        valid, valid2;
  logic [1:0]  id,    id2;
  logic [7:0]  sum,   sum2;
  logic        carry, carry2;
  logic        busy,  busy2;
  logic [15:0] ops;
  logic [1:0]  ops2;

  int n_checks = 0;
  int n_errors = 0;

  assign op_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign op_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  adder_share_arbiter #(.NREQ(4), .WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .rsp_valid(valid), .rsp_ready(rsp_ready), .rsp_id(id),
    .rsp_sum(sum), .rsp_carry(carry), .busy(busy), .ops_done(ops)
  );

  adder_share_arbiter #(.NREQ(4), .WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt2), .rsp_valid(valid2), .rsp_ready(rsp_ready), .rsp_id(id2),
    .rsp_sum(sum2), .rsp_carry(carry2), .busy(busy2), .ops_done(ops2)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    req       = r;
    rsp_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one transaction at a time (pick, add, respond).
  int         m_phase = 0;
  int         m_ptr   = 3;
  int         m_win   = 0;
  int         m_a     = 0;
  int         m_b     = 0;
  int         m_ops   = 0;
  logic [3:0] m_gnt   = '0;
  logic       m_valid = 1'b0;
  logic [1:0] m_id    = '0;
  logic [7:0] m_sum   = '0;
  logic       m_carry = 1'b0;

  // Reference model update on each rising edge or asynchronous reset.
  always @(posedge clk or negedge rst_n) begin : model
    int w;
    int idx;
    int s;
    if (!rst_n) begin
      m_phase <= 0; m_ptr <= 3; m_win <= 0; m_a <= 0; m_b <= 0; m_ops <= 0;
      m_gnt <= '0; m_valid <= 1'b0; m_id <= '0; m_sum <= '0; m_carry <= 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (req != 4'b0000) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
              idx = (m_ptr + k) % 4;
              if (w < 0 && req[2'(idx)]) w = idx;
            end
            m_a     <= int'(a_arr[2'(w)]);
            m_b     <= int'(b_arr[2'(w)]);
            m_win   <= w;
            m_ptr   <= w;
            m_gnt   <= 4'(1 << w);
            m_phase <= 1;
          end else begin
            m_gnt <= '0;
          end
        end
        1: begin
          s       = m_a + m_b;
          m_sum   <= 8'(s % 256);
          m_carry <= (s >= 256);
          m_id    <= 2'(m_win);
          m_gnt   <= '0;
          m_valid <= 1'b1;
          m_phase <= 2;
        end
        default: begin
          if (rsp_ready) begin
            m_valid <= 1'b0;
            m_ops   <= m_ops + 1;
            m_phase <= 0;
          end
        end
      endcase
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("model_gnt",    64'(gnt),   64'(m_gnt));
    checkOutput("model_valid",  64'(valid), 64'(m_valid));
    checkOutput("model_id",     64'(id),    64'(m_id));
    checkOutput("model_sum",    64'(sum),   64'(m_sum));
    checkOutput("model_carry",  64'(carry), 64'(m_carry));
    checkOutput("model_busy",   64'(busy),  64'(m_phase != 0));
    checkOutput("model_ops",    64'(ops),   64'(m_ops));
    checkOutput("model_gnt2",   64'(gnt2),  64'(m_gnt));
    checkOutput("model_valid2", 64'(valid2), 64'(m_valid));
    checkOutput("model_id2",    64'(id2),   64'(m_id));
    checkOutput("model_sum2",   64'(sum2),  64'(m_sum));
    checkOutput("model_carry2", 64'(carry2), 64'(m_carry));
    checkOutput("model_busy2",  64'(busy2), 64'(m_phase != 0));
    checkOutput("model_ops2",   64'(ops2),  64'((m_ops > 3) ? 3 : m_ops));
  end

  logic [3:0] rr_gnt   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] rr_sum   [4] = '{8'h13, 8'h23, 8'h33, 8'h33};
  logic       rr_carry [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Directed scenarios with literal expectations.
  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 8'h00;
      b_arr[i] = 8'h00;
    end
    tick(); tick();
    checkOutput("reset_gnt",   64'(gnt),   64'h0);
    checkOutput("reset_valid", 64'(valid), 64'h0);
    checkOutput("reset_busy",  64'(busy),  64'h0);
    checkOutput("reset_ops",   64'(ops),   64'h0);
    rst_n = 1'b1;

    // Single request from requester 1.
    a_arr[1] = 8'h12; b_arr[1] = 8'h34;
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("single_gnt",   64'(gnt),   64'h2);
    checkOutput("single_busy",  64'(busy),  64'h1);
    checkOutput("single_valid0", 64'(valid), 64'h0);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("single_valid", 64'(valid), 64'h1);
    checkOutput("single_id",    64'(id),    64'h1);
    checkOutput("single_sum",   64'(sum),   64'h46);
    checkOutput("single_carry", 64'(carry), 64'h0);
    checkOutput("single_gnt_off", 64'(gnt), 64'h0);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("single_done_valid", 64'(valid), 64'h0);
    checkOutput("single_ops",   64'(ops),  64'h1);
    checkOutput("sat_ops_1",    64'(ops2), 64'h1);

    // Overflow 0xFF + 0x02.
    a_arr[0] = 8'hFF; b_arr[0] = 8'h02;
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("ovf1_gnt", 64'(gnt), 64'h1);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("ovf1_sum",   64'(sum),   64'h01);
    checkOutput("ovf1_carry", 64'(carry), 64'h1);
    checkOutput("ovf1_id",    64'(id),    64'h0);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("sat_ops_2", 64'(ops2), 64'h2);

    // Overflow 0x80 + 0x80, operands disturbed after the grant.
    a_arr[0] = 8'h80; b_arr[0] = 8'h80;
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("ovf2_gnt", 64'(gnt), 64'h1);
    a_arr[0] = 8'h11; b_arr[0] = 8'h11;
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("ovf2_sum",   64'(sum),   64'h00);
    checkOutput("ovf2_carry", 64'(carry), 64'h1);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("ovf2_ops",  64'(ops),  64'h3);
    checkOutput("sat_ops_3", 64'(ops2), 64'h3);

    // Backpressure on requester 2's response.
    a_arr[2] = 8'h05; b_arr[2] = 8'h07;
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("bp_gnt", 64'(gnt), 64'h4);
    applyStimulus(4'b0000, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", 64'(valid), 64'h1);
      checkOutput("bp_sum",   64'(sum),   64'h0C);
      checkOutput("bp_id",    64'(id),    64'h2);
      checkOutput("bp_gnt0",  64'(gnt),   64'h0);
      checkOutput("bp_busy",  64'(busy),  64'h1);
      tick();
    end
    a_arr[3] = 8'h7F; b_arr[3] = 8'h01;
    applyStimulus(4'b1000, 1'b1);
    tick();
    checkOutput("bp_release_valid", 64'(valid), 64'h0);
    checkOutput("bp_release_busy",  64'(busy),  64'h0);
    checkOutput("bp_release_gnt",   64'(gnt),   64'h0);
    checkOutput("bp_ops",           64'(ops),   64'h4);
    checkOutput("sat_ops_4",        64'(ops2),  64'h3);
    tick();
    checkOutput("bp_next_gnt", 64'(gnt), 64'h8);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("r3_sum",   64'(sum),   64'h80);
    checkOutput("r3_carry", 64'(carry), 64'h0);
    checkOutput("r3_id",    64'(id),    64'h3);
    tick();
    checkOutput("r3_ops",    64'(ops),  64'h5);
    checkOutput("sat_ops_5", 64'(ops2), 64'h3);

    // Asynchronous reset in the middle of a response.
    a_arr[1] = 8'hAA; b_arr[1] = 8'h55;
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("rst_pre_gnt", 64'(gnt), 64'h2);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("rst_pre_sum", 64'(sum), 64'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(valid), 64'h0);
    checkOutput("rst_async_sum",   64'(sum),   64'h0);
    checkOutput("rst_async_id",    64'(id),    64'h0);
    checkOutput("rst_async_busy",  64'(busy),  64'h0);
    checkOutput("rst_async_ops",   64'(ops),   64'h0);
    tick(); tick();
    checkOutput("rst_hold_valid", 64'(valid), 64'h0);
    checkOutput("rst_hold_gnt",   64'(gnt),   64'h0);

    // Round robin with all four requesting after reset release.
    a_arr[0] = 8'h10; a_arr[1] = 8'h21; a_arr[2] = 8'h32; a_arr[3] = 8'h43;
    b_arr[0] = 8'h03; b_arr[1] = 8'h02; b_arr[2] = 8'h01; b_arr[3] = 8'hF0;
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rr_gnt", 64'(gnt), 64'(rr_gnt[k % 4]));
      tick();
      checkOutput("rr_gnt_off", 64'(gnt),   64'h0);
      checkOutput("rr_valid",   64'(valid), 64'h1);
      checkOutput("rr_id",      64'(id),    64'(k % 4));
      checkOutput("rr_sum",     64'(sum),   64'(rr_sum[k % 4]));
      checkOutput("rr_carry",   64'(carry), 64'(rr_carry[k % 4]));
      tick();
      checkOutput("rr_ops", 64'(ops), 64'(k + 1));
    end
    applyStimulus(4'b0000, 1'b0);
    tick(); tick();
    checkOutput("end_gnt",  64'(gnt),  64'h0);
    checkOutput("end_busy", 64'(busy), 64'h0);
    checkOutput("end_ops2", 64'(ops2), 64'h3);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
